clock_step_gen: RTL
===================

# clock_step_gen

Parametrised clock divider with run, single-step and hold modes. It replaces the fixed divide-by-4 slow-clock generator in front of the CPU core. The divide ratio is programmable at run time. The debug front panel can stop the core clock cleanly, or issue exactly one core clock period per button press, so intermediate CPU states can be inspected. It produces a glitch-free divided clock and a single-cycle rising-edge strobe, both registered in the `clk` domain.

## Interface
Parameters:
- `CNT_W`, 25: width of the half-period counter and of `div_i`.
- `DIV_RST`, 1: reset value of the half-period register (half-period = `DIV_RST`+1 cycles).

Ports:
- `clk`, in, 1: system clock (50 MHz).
- `rst_n`, in, 1: reset, asynchronous and active-low. Clears all state.
- `div_i`, in, `CNT_W`: new half-period minus one.
- `div_load`, in, 1: one-cycle strobe that latches `div_i` into `div_r`.
- `mode_i`, in, 2: 00 = run, 01 = single-step, 10/11 = hold. Synchronous to `clk`; pre-synchronised upstream.
- `step_i`, in, 1: single-cycle step request. Already debounced and edge-detected upstream.
- `clk_o`, out, 1: divided clock (registered).
- `rise_o`, out, 1: high for exactly one `clk` cycle, in the cycle in which `clk_o` is first high.
- `busy_o`, out, 1: high while a single-step period is in progress.

## Operation
- Internal state:
  - `div_r` (`CNT_W` bits).
  - `cnt` (`CNT_W` bits).
  - FSM states: RUN, PARK, STEP.
- `div_load` writes `div_r` on the next edge, in any state, and takes effect immediately.
- Toggle condition is `cnt >= div_r`:
  - Lowering `div_r` below the current `cnt` causes a toggle on the next edge; `cnt` never wraps through 2^`CNT_W`.
  - `div_r`=0 gives `clk`/2.
- RUN:
  - On a toggle edge: `clk_o` flips and `cnt` is set to 0. Otherwise `cnt` increments.
  - Period = 2·(`div_r`+1) cycles.
  - If `mode_i`≠00 and `clk_o`=0: go to PARK on the next edge. The low phase may be truncated.
  - If `mode_i`≠00 and `clk_o`=1: the high phase completes. On the falling toggle edge, go to PARK.
  - No high pulse is ever shortened.
- PARK:
  - `clk_o`=0 and `cnt` held at 0.
  - `mode_i`=00: go to RUN on the next edge. The first rise comes `div_r`+1 edges later.
  - `mode_i`=01 with `step_i`=1: on that edge go to STEP, `clk_o`←1, `rise_o`←1, `busy_o`←1, `cnt`←0.
  - `step_i` in hold mode is ignored.
- STEP:
  - `cnt` counts while `clk_o` is high.
  - On the toggle edge: `clk_o`←0, `busy_o`←0, go to PARK.
  - Resulting pulse is high for exactly `div_r`+1 cycles.
  - `step_i` while `busy_o`=1 is ignored; requests are not queued.
  - A `mode_i` change during STEP does not abort the step. It is evaluated in PARK afterwards.
- `rise_o` is asserted on every 0→1 transition of `clk_o`, in both RUN and STEP.

## Timing
- Reset values: `clk_o`=0, `rise_o`=0, `busy_o`=0, `cnt`=0, `div_r`=`DIV_RST`, state=RUN. Free-running output starts immediately after reset.
- With reset defaults, `clk_o` rises on the 2nd `clk` edge after `rst_n` deasserts; period is 4 cycles.
- Latencies:
  - `div_load` to `div_r` update: 1 edge.
  - `step_i` to `clk_o` high: 1 edge.
  - PARK to RUN: 1 edge.
- Asynchronous reset mid-step or mid-run: all outputs return to reset values immediately; no completion of the pulse.
- Simultaneous `div_load` and toggle edge: the toggle uses the old `div_r`; the next comparison uses the new value.
- All outputs are driven directly from flops; no combinational path from inputs to outputs.

## Test plan
- Reset, `mode_i`=00, defaults → `clk_o` rises at edge 2, period 4, `rise_o` one cycle wide at each rise; `busy_o`=0.
- `div_i`=4, `div_load` pulse → period 10 (5 high/5 low) from the next toggle. Then load 0 while `cnt`=3 → toggle on the next edge, then period 2.
- `mode_i`=10 asserted while `clk_o`=1 with `div_r`=4 → high phase completes at 5 cycles, then `clk_o` stays 0. Back to 00 → first rise 5 edges later.
- `mode_i`=01 in PARK, `div_r`=3, one `step_i` pulse → exactly one `clk_o` high pulse of 4 cycles and one `rise_o`. `busy_o` high for those 4 cycles. A second `step_i` during busy produces no extra pulse.
- `rst_n` asserted 2 cycles into a step → `clk_o`, `busy_o` and `rise_o` go to 0 asynchronously. After release, RUN with `div_r`=1, period 4.
- `step_i` pulses while `mode_i`=00 or 10 → no effect on `clk_o`/`busy_o`.

Source files
------------

// File: rtl/clock_step_gen.sv
// clock_step_gen: programmable clock divider for the CPU core clock, with
// run, single-step and hold modes driven from the debug front panel.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   div_i    in   new half-period minus one
//   div_load in   one-cycle strobe, latches div_i into the half-period register
//   mode_i   in   00 run, 01 single-step, 10/11 hold
//   step_i   in   one-cycle step request (debounced, edge-detected upstream)
//   clk_o    out  divided clock, registered
//   rise_o   out  one-cycle strobe in the first cycle clk_o is high
//   busy_o   out  high while a single-step pulse is in progress
//
// state | meaning
// RUN   | free-running divide, clk_o toggles every div_r+1 cycles
// PARK  | clk_o held low, waiting for run mode or a step request
// STEP  | one high pulse of div_r+1 cycles in progress
module clock_step_gen #(
   parameter int CNT_W   = 25,
   parameter int DIV_RST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] div_i,
   input  logic             div_load,
   input  logic [1:0]       mode_i,
   input  logic             step_i,
   output logic             clk_o,
   output logic             rise_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      PARK = 2'd1,
      STEP = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] div_r;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             clk_nxt, rise_nxt, busy_nxt;
   logic             toggle;
   logic             hold_req;

   // >= rather than == so that lowering div_r below the running count
   // toggles at once instead of wrapping the counter.
   assign toggle   = (cnt >= div_r);
   assign hold_req = (mode_i != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_r <= CNT_W'(DIV_RST);
      end else if (div_load) begin
         div_r <= div_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RUN;
         cnt    <= '0;
         clk_o  <= 1'b0;
         rise_o <= 1'b0;
         busy_o <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         clk_o  <= clk_nxt;
         rise_o <= rise_nxt;
         busy_o <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clk_nxt   = clk_o;
      rise_nxt  = 1'b0;
      busy_nxt  = busy_o;
      case (state)
         RUN: begin
            busy_nxt = 1'b0;
            if (hold_req && !clk_o) begin
               // Low phase may be cut short; a high phase never is.
               state_nxt = PARK;
               cnt_nxt   = '0;
            end else if (toggle) begin
               clk_nxt  = ~clk_o;
               rise_nxt = ~clk_o;
               cnt_nxt  = '0;
               if (clk_o && hold_req) begin
                  state_nxt = PARK;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         PARK: begin
            clk_nxt  = 1'b0;
            busy_nxt = 1'b0;
            cnt_nxt  = '0;
            if (mode_i == 2'b00) begin
               state_nxt = RUN;
            end else if (mode_i == 2'b01 && step_i) begin
               state_nxt = STEP;
               clk_nxt   = 1'b1;
               rise_nxt  = 1'b1;
               busy_nxt  = 1'b1;
            end
         end
         STEP: begin
            // Mode changes and further step requests wait until PARK.
            if (toggle) begin
               state_nxt = PARK;
               clk_nxt   = 1'b0;
               busy_nxt  = 1'b0;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = RUN;
            clk_nxt   = 1'b0;
            busy_nxt  = 1'b0;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule
